encap_tunnel_lookup: RTL

Requester for the encap tunnel tables, and the initiator side of their application read ports. It takes a lookup request (tag plus two precomputed hash indexes), reads both hash-table banks in parallel and compares the bucket entries against the tag. On a hit it fetches the tunnel value record and returns hit/miss plus the value to the encap pipeline. It handles one lookup at a time and keeps saturating hit/miss statistics.

---
 rtl/encap_tunnel_defs_pkg.sv | 34 +++
 rtl/encap_tunnel_lookup_bucket_match.sv | 60 ++++++
 rtl/encap_tunnel_lookup.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/encap_tunnel_defs_pkg.sv
// Shared encap tunnel table definitions: entry layout {valid, tag, ptr}, lookup FSM
// states, and the saturating counter helper.
package encap_tunnel_defs_pkg;

  localparam int DEPTH_NBITS_DEF       = 10;
  localparam int ENTRIES_DEF           = 4;
  localparam int TAG_NBITS_DEF         = 20;
  localparam int VALUE_DEPTH_NBITS_DEF = 10;
  localparam int VALUE_NBITS_DEF       = 352;

  localparam int ENTRY_NBITS     = 1 + TAG_NBITS_DEF + VALUE_DEPTH_NBITS_DEF;
  localparam int ENTRY_PTR_LSB   = 0;
  localparam int ENTRY_TAG_LSB   = VALUE_DEPTH_NBITS_DEF;
  localparam int ENTRY_VALID_BIT = VALUE_DEPTH_NBITS_DEF + TAG_NBITS_DEF;

  typedef struct packed {
    logic                             valid;
    logic [TAG_NBITS_DEF-1:0]         tag;
    logic [VALUE_DEPTH_NBITS_DEF-1:0] ptr;
  } tunnel_entry_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HT_WAIT  = 3'd1,
    CMP      = 3'd2,
    VAL_WAIT = 3'd3,
    RESP     = 3'd4
  } lookup_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/encap_tunnel_lookup_bucket_match.sv
// Combinational tag match across two hash buckets. Bank0 beats bank1, and the lowest
// entry index wins within a bank.
module encap_tunnel_bucket_match
  import encap_tunnel_defs_pkg::*;
#(
  parameter int ENTRIES           = ENTRIES_DEF,
  parameter int TAG_NBITS         = TAG_NBITS_DEF,
  parameter int VALUE_DEPTH_NBITS = VALUE_DEPTH_NBITS_DEF,
  parameter int PTR_LSB           = ENTRY_PTR_LSB,
  parameter int TAG_LSB           = ENTRY_TAG_LSB,
  parameter int VALID_BIT         = ENTRY_VALID_BIT,
  parameter int ENT_NBITS         = 1 + TAG_NBITS + VALUE_DEPTH_NBITS,
  parameter int IDX_NBITS         = $clog2(ENTRIES)
) (
  input  logic [ENTRIES*ENT_NBITS-1:0] bucket0,
  input  logic [ENTRIES*ENT_NBITS-1:0] bucket1,
  input  logic [TAG_NBITS-1:0]         tag,
  output logic                         hit,
  output logic                         bank,
  output logic [IDX_NBITS-1:0]         entry,
  output logic [VALUE_DEPTH_NBITS-1:0] ptr,
  output logic                         multi_hit
);

  logic [ENT_NBITS-1:0] cur;

  // Scan from lowest priority to highest so the last match seen is the winner;
  // any match after the first one flags a multi-hit.
  always_comb begin
    hit       = 1'b0;
    bank      = 1'b0;
    entry     = '0;
    ptr       = '0;
    multi_hit = 1'b0;
    cur       = '0;
    for (int b = 1; b >= 0; b--) begin
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (b == 0) begin
          cur = bucket0[i*ENT_NBITS +: ENT_NBITS];
        end else begin
          cur = bucket1[i*ENT_NBITS +: ENT_NBITS];
        end
        if (cur[VALID_BIT] && (cur[TAG_LSB +: TAG_NBITS] == tag)) begin
          if (hit) begin
            multi_hit = 1'b1;
          end else begin
            multi_hit = multi_hit;
          end
          hit   = 1'b1;
          bank  = b[0];
          entry = i[IDX_NBITS-1:0];
          ptr   = cur[PTR_LSB +: VALUE_DEPTH_NBITS];
        end else begin
          hit = hit;
        end
      end
    end
  end

endmodule

// File: rtl/encap_tunnel_lookup.sv
// Encap tunnel lookup requester: reads both hash banks, matches the tag, fetches the
// value record on a hit and returns the result with saturating hit/miss counters.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif
module encap_tunnel_lookup
  import encap_tunnel_defs_pkg::*;
#(
  parameter int DEPTH_NBITS       = DEPTH_NBITS_DEF,
  parameter int ENTRIES           = ENTRIES_DEF,
  parameter int TAG_NBITS         = TAG_NBITS_DEF,
  parameter int VALUE_DEPTH_NBITS = VALUE_DEPTH_NBITS_DEF,
  parameter int VALUE_NBITS       = VALUE_NBITS_DEF
) (
  input  logic                                                   clk,
  input  logic                                                   `RESET_SIG,
  input  logic                                                   req_valid,
  output logic                                                   req_ready,
  input  logic [TAG_NBITS-1:0]                                   req_tag,
  input  logic [DEPTH_NBITS-1:0]                                 req_idx0,
  input  logic [DEPTH_NBITS-1:0]                                 req_idx1,
  output logic                                                   tunnel_hash_table0_rd,
  output logic [DEPTH_NBITS-1:0]                                 tunnel_hash_table0_raddr,
  input  logic                                                   tunnel_hash_table0_ack,
  input  logic [ENTRIES*(1+TAG_NBITS+VALUE_DEPTH_NBITS)-1:0]     tunnel_hash_table0_rdata,
  output logic                                                   tunnel_hash_table1_rd,
  output logic [DEPTH_NBITS-1:0]                                 tunnel_hash_table1_raddr,
  input  logic                                                   tunnel_hash_table1_ack,
  input  logic [ENTRIES*(1+TAG_NBITS+VALUE_DEPTH_NBITS)-1:0]     tunnel_hash_table1_rdata,
  output logic                                                   tunnel_value_rd,
  output logic [VALUE_DEPTH_NBITS-1:0]                           tunnel_value_raddr,
  input  logic                                                   tunnel_value_ack,
  input  logic [VALUE_NBITS-1:0]                                 tunnel_value_rdata,
  output logic                                                   rsp_valid,
  input  logic                                                   rsp_ready,
  output logic                                                   rsp_hit,
  output logic                                                   rsp_bank,
  output logic [$clog2(ENTRIES)-1:0]                             rsp_entry,
  output logic                                                   rsp_multi_hit,
  output logic [VALUE_NBITS-1:0]                                 rsp_value,
  output logic [31:0]                                            hit_cnt,
  output logic [31:0]                                            miss_cnt
);

  localparam int ENT_NBITS    = 1 + TAG_NBITS + VALUE_DEPTH_NBITS;
  localparam int BUCKET_NBITS = ENTRIES * ENT_NBITS;
  localparam int IDX_NBITS    = $clog2(ENTRIES);

  lookup_state_e               state;
  logic [TAG_NBITS-1:0]        tag_q;
  logic [BUCKET_NBITS-1:0]     bucket0_q;
  logic [BUCKET_NBITS-1:0]     bucket1_q;
  logic                        done0;
  logic                        done1;
  logic                        done0_next;
  logic                        done1_next;
  logic                        m_hit;
  logic                        m_bank;
  logic [IDX_NBITS-1:0]        m_entry;
  logic [VALUE_DEPTH_NBITS-1:0] m_ptr;
  logic                        m_multi;

  assign done0_next = done0 | tunnel_hash_table0_ack;
  assign done1_next = done1 | tunnel_hash_table1_ack;

  encap_tunnel_bucket_match #(
    .ENTRIES          (ENTRIES),
    .TAG_NBITS        (TAG_NBITS),
    .VALUE_DEPTH_NBITS(VALUE_DEPTH_NBITS),
    .PTR_LSB          (0),
    .TAG_LSB          (VALUE_DEPTH_NBITS),
    .VALID_BIT        (VALUE_DEPTH_NBITS + TAG_NBITS)
  ) u_match (
    .bucket0  (bucket0_q),
    .bucket1  (bucket1_q),
    .tag      (tag_q),
    .hit      (m_hit),
    .bank     (m_bank),
    .entry    (m_entry),
    .ptr      (m_ptr),
    .multi_hit(m_multi)
  );

  // Lookup FSM; every output is a register. Acks outside their wait state fall through.
  always_ff @(posedge clk) begin
    if (`RESET_SIG) begin
      state                    <= IDLE;
      req_ready                <= 1'b0;
      tag_q                    <= '0;
      bucket0_q                <= '0;
      bucket1_q                <= '0;
      done0                    <= 1'b0;
      done1                    <= 1'b0;
      tunnel_hash_table0_rd    <= 1'b0;
      tunnel_hash_table1_rd    <= 1'b0;
      tunnel_hash_table0_raddr <= '0;
      tunnel_hash_table1_raddr <= '0;
      tunnel_value_rd          <= 1'b0;
      tunnel_value_raddr       <= '0;
      rsp_valid                <= 1'b0;
      rsp_hit                  <= 1'b0;
      rsp_bank                 <= 1'b0;
      rsp_entry                <= '0;
      rsp_multi_hit            <= 1'b0;
      rsp_value                <= '0;
      hit_cnt                  <= 32'd0;
      miss_cnt                 <= 32'd0;
    end else begin
      tunnel_hash_table0_rd <= 1'b0;
      tunnel_hash_table1_rd <= 1'b0;
      tunnel_value_rd       <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            tag_q                    <= req_tag;
            tunnel_hash_table0_raddr <= req_idx0;
            tunnel_hash_table1_raddr <= req_idx1;
            tunnel_hash_table0_rd    <= 1'b1;
            tunnel_hash_table1_rd    <= 1'b1;
            done0                    <= 1'b0;
            done1                    <= 1'b0;
            req_ready                <= 1'b0;
            state                    <= HT_WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        HT_WAIT: begin
          if (tunnel_hash_table0_ack && !done0) begin
            bucket0_q <= tunnel_hash_table0_rdata;
            done0     <= 1'b1;
          end
          if (tunnel_hash_table1_ack && !done1) begin
            bucket1_q <= tunnel_hash_table1_rdata;
            done1     <= 1'b1;
          end
          if (done0_next && done1_next) begin
            state <= CMP;
          end
        end
        CMP: begin
          rsp_hit       <= m_hit;
          rsp_bank      <= m_bank;
          rsp_entry     <= m_entry;
          rsp_multi_hit <= m_multi;
          if (m_hit) begin
            tunnel_value_rd    <= 1'b1;
            tunnel_value_raddr <= m_ptr;
            state              <= VAL_WAIT;
          end else begin
            rsp_value <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        VAL_WAIT: begin
          if (tunnel_value_ack) begin
            rsp_value <= tunnel_value_rdata;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
            if (rsp_hit) begin
              hit_cnt <= sat_inc32(hit_cnt);
            end else begin
              miss_cnt <= sat_inc32(miss_cnt);
            end
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
